insn_fetch_unit: RTL and testbench
==================================

// Module: insn_fetch_unit
// PURPOSE
//  Instruction fetch/prefetch stage directly upstream of insn_decoder. Issues sequential reads to
//  instruction memory through a req/ack handshake and buffers fetched words in a small FIFO.
//  Presents one word per cycle, with its address, to the decoder and holds it while the pipeline
//  stalls. Discards buffered and in-flight words when PC is redirected.
// PARAMETERS
//  DEPTH     4             prefetch FIFO entries, power of two, >=2
//  RESET_PC  32'h00000000  first fetch address after reset
//  NOP_WORD  32'h00000000  word driven to decoder when no valid entry
// PORTS
//  clk           in   1   clock; all state changes on rising edge
//  rst           in   1   synchronous reset, active low
//  im_req        out  1   instruction memory read request
//  im_addr       out  32  read address, word aligned
//  im_ack        in   1   request accepted; im_rdata valid this cycle
//  im_rdata      in   32  read data
//  redir         in   1   PC redirect (branch / PC write), single-cycle pulse
//  redir_addr    in   32  new fetch address; bits[1:0] ignored, forced 0
//  stall         in   1   decoder hazard (d_hazard); head must not advance
//  advance       in   1   decoder consumes head (d_pcincr)
//  word          out  32  head instruction word, or NOP_WORD when empty
//  word_pc       out  32  address of head word
//  word_valid    out  1   head entry valid
//  fetch_cnt     out  32  retired-fetch counter (FETCH_PERF_EN only)
// BEHAVIOUR
//  Reset (rst==0 at edge): FIFO empty, fetch_addr=RESET_PC, state=IDLE, im_req=0,
//    im_addr=RESET_PC, word_valid=0, word=NOP_WORD, word_pc=RESET_PC, fetch_cnt=0.
//    Reset mid-request drops the request; an ack in the reset cycle is ignored.
//  Credit: a new request may be issued only if count + outstanding(0/1) < DEPTH.
//    At most one request is outstanding.
//  FSM:
//    IDLE: if credit -> im_req=1, im_addr=fetch_addr, go REQ.
//    REQ:  im_req and im_addr held stable until im_ack.
//          On ack: push {im_rdata, im_addr}; fetch_addr += 4 (mod 2^32, FFFFFFFC -> 0).
//          If credit remains, issue next request back-to-back next cycle, else go IDLE.
//    DROP: entered when redir occurs while in REQ. Hold im_req/im_addr until ack and discard the
//          data, then request fetch_addr (already = redir_addr).
//  Minimum latency: redir at cycle N -> im_req with redir_addr at N+1 (from IDLE) or after drop;
//    ack at M -> word_valid=1 at M+1 when FIFO was empty.
//  Take: take = advance & word_valid & ~stall. Pops the head; next entry shows the following
//    cycle. stall=1 freezes word/word_pc/word_valid regardless of advance.
//  Simultaneous events:
//    - push and take in the same cycle: count unchanged; allowed even when count==DEPTH-1.
//    - redir has priority over take and ack. FIFO is cleared; fetch_addr=redir_addr; the ack of
//      that cycle is discarded; word_valid=0 the next cycle.
//    - redir while in DROP: update fetch_addr only; stay in DROP.
//  Full: count==DEPTH implies no request (credit rule); no ack can arrive.
//  Empty: word_valid=0, word=NOP_WORD, word_pc=fetch_addr of the pending word.
//  FIFO: circular, pointers log2(DEPTH)+1 bits; full/empty from MSB compare; wrap-around silent.
// CONFIGURATION
//  FETCH_PERF_EN defined: fetch_cnt increments on every accepted (pushed) ack, wraps at 2^32,
//    and is cleared by reset only.
//  FETCH_PERF_EN undefined: fetch_cnt port is absent and no counter logic is built.
// STRUCTURE
//  Shared package/header (cpu_defs): FSM state encodings (IDLE, REQ, DROP), WORD_W=32,
//    PC_STEP=4, NOP encoding.
//  One sub-module: fetch_fifo (DEPTH x 64-bit {pc, word}; push/pop/clear ports, count output).
//    Control FSM and address counter stay in insn_fetch_unit.
// TESTING
//  1 Reset, memory acks every cycle, advance=1 -> im_addr 0,4,8,..; word_pc follows one cycle
//    behind the acks; no bubbles after fill.
//  2 stall=1, advance=1 for 10 cycles with ack always 1 -> exactly DEPTH=4 entries fetched,
//    im_req=0, head word unchanged; release stall -> pops resume in order.
//  3 Ack delayed 3 cycles -> im_addr and im_req stable across the wait; word_valid=0 with
//    word=NOP_WORD until first data.
//  4 redir to 32'h100 while REQ for 0x8 is outstanding -> ack data for 0x8 dropped; next request
//    is 0x100; the first valid word_pc is 0x100.
//  5 redir to 32'hFFFFFFF8 -> fetches FFFFFFF8, FFFFFFFC, 0, 4; redir in the same cycle as take
//    and ack -> FIFO empty next cycle.
//  6 rst low mid-REQ with ack in the reset cycle -> all outputs at reset values; first request
//    after reset is RESET_PC. With FETCH_PERF_EN, fetch_cnt==pushes, and the count is 0 after
//    reset.

Source files
------------

// File: rtl/insn_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: word width, PC step,
// NOP encoding, fetch FSM state encoding and the FIFO entry layout.
package insn_fetch_unit_pkg;

  localparam int WORD_W = 32;

  // Sequential fetch stride in bytes (one 32-bit word).
  localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

  // Default word handed to the decoder when nothing valid is buffered.
  localparam logic [WORD_W-1:0] NOP_ENC = 32'h0000_0000;

  // Fetch control states.
  //   ST_IDLE : no request outstanding
  //   ST_REQ  : request outstanding, its data will be buffered
  //   ST_DROP : request outstanding, its data will be discarded (PC redirected)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // One prefetch buffer entry: the instruction word and the address it came from.
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] word;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return addr & ~(WORD_W'(3));
  endfunction

endpackage

// File: rtl/insn_fetch_unit_fifo.sv
// Prefetch FIFO for the fetch stage: DEPTH entries of {pc, word}.
// Circular buffer with one extra pointer bit so full and empty are told apart
// by the pointer MSBs. Clear empties the buffer in one cycle. A push into a
// full buffer is only accepted together with a pop.
module insn_fetch_unit_fifo
  import insn_fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head_entry,
  output logic         empty,
  output logic [CW-1:0] count
);

  localparam int AW = CW - 1;

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  fetch_entry_t  mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head_entry = mem[rd_ptr[AW-1:0]];

  // Pointer update: synchronous reset and clear both empty the buffer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + CW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + CW'(1);
    end
  end

  // Entry storage: written on push, read combinationally at the head.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are meaningful, so resetting the data would only cost logic.
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/insn_fetch_unit.sv
// Instruction fetch / prefetch stage feeding insn_decoder.
// Issues sequential word reads over a req/ack interface (one outstanding
// request at most), buffers the returned words with their addresses in a
// small FIFO and presents the head to the decoder. A PC redirect flushes the
// buffer and discards any read still in flight.
// Optional feature: define FETCH_PERF_EN to add the fetch_cnt port and a
// counter of accepted (buffered) fetches.
module insn_fetch_unit
  import insn_fetch_unit_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WORD_W-1:0] NOP_WORD = NOP_ENC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              im_req,
  output logic [WORD_W-1:0] im_addr,
  input  logic              im_ack,
  input  logic [WORD_W-1:0] im_rdata,
  input  logic              redir,
  input  logic [WORD_W-1:0] redir_addr,
  input  logic              stall,
  input  logic              advance,
  output logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] word_pc,
  output logic              word_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [WORD_W-1:0] fetch_cnt
`endif
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e      state, state_n;
  logic [WORD_W-1:0] fetch_addr, fetch_addr_n;
  logic [WORD_W-1:0] req_addr, req_addr_n;
  logic [WORD_W-1:0] redir_target;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_clear;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_after_pop;
  logic [CW-1:0]     count_after_push;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  insn_fetch_unit_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clear      (fifo_clear),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head_entry (head_entry),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign redir_target = align_word(redir_addr);

  // The request is registered: it is raised the cycle after the decision to
  // fetch and held with a stable address until acknowledged.
  assign im_req  = (state != ST_IDLE);
  assign im_addr = req_addr;

  // Decoder-facing head: NOP and the pending fetch address while empty.
  assign word_valid = ~fifo_empty;
  assign word       = word_valid ? head_entry.word : NOP_WORD;
  assign word_pc    = word_valid ? head_entry.pc   : fetch_addr;

  // A take pops the head unless a redirect flushes the buffer this cycle.
  assign fifo_pop   = advance & word_valid & ~stall & ~redir;
  assign push_entry = '{pc: req_addr, word: im_rdata};

  // Occupancy the buffer will have after this cycle, used for the credit
  // check that decides whether another request may follow.
  assign count_after_pop  = fifo_count - CW'(fifo_pop);
  assign count_after_push = count_after_pop + CW'(1);

  // Next-state, address and FIFO control. A redirect overrides ack and take.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n      = state;
    fetch_addr_n = fetch_addr;
    req_addr_n   = req_addr;
    fifo_push    = 1'b0;
    fifo_clear   = 1'b0;

    if (redir) begin
      fifo_clear   = 1'b1;
      fetch_addr_n = redir_target;
      unique case (state)
        ST_IDLE: begin
          // Buffer is now empty, so credit is guaranteed.
          state_n    = ST_REQ;
          req_addr_n = redir_target;
        end
        ST_REQ, ST_DROP: begin
          if (im_ack) begin
            // The old request completed this cycle; its data is discarded
            // and the new address can be requested straight away.
            state_n    = ST_REQ;
            req_addr_n = redir_target;
          end else begin
            // Old request still in flight: wait for it and throw it away.
            state_n = ST_DROP;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (count_after_pop < DEPTH_C) begin
            state_n    = ST_REQ;
            req_addr_n = fetch_addr;
          end
        end
        ST_REQ: begin
          if (im_ack) begin
            fifo_push    = 1'b1;
            fetch_addr_n = fetch_addr + PC_STEP;
            req_addr_n   = fetch_addr + PC_STEP;
            state_n      = (count_after_push < DEPTH_C) ? ST_REQ : ST_IDLE;
          end
        end
        ST_DROP: begin
          if (im_ack) begin
            // Stale data discarded; fetch_addr already holds the redirect.
            req_addr_n = fetch_addr;
            state_n    = (count_after_pop < DEPTH_C) ? ST_REQ : ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Control state, fetch address and request address registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      fetch_addr <= RESET_PC;
      req_addr   <= RESET_PC;
    end else begin
      state      <= state_n;
      fetch_addr <= fetch_addr_n;
      req_addr   <= req_addr_n;
    end
  end

`ifdef FETCH_PERF_EN
  // Counts buffered fetches; wraps silently, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt <= '0;
    end else if (fifo_push) begin
      fetch_cnt <= fetch_cnt + WORD_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Self-checking bench for insn_fetch_unit. A memory model answers requests
// with an address-derived word; a scoreboard tracks, at the level of "which
// addresses should be buffered, in which order", what the decoder must see.
// Build with FETCH_PERF_EN defined to also check fetch_cnt.
module tb_insn_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        redir;
  logic [31:0] redir_addr;
  logic        stall;
  logic        advance;
  logic [31:0] word;
  logic [31:0] word_pc;
  logic        word_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
`endif

  insn_fetch_unit #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC),
    .NOP_WORD(NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .im_req    (im_req),
    .im_addr   (im_addr),
    .im_ack    (im_ack),
    .im_rdata  (im_rdata),
    .redir     (redir),
    .redir_addr(redir_addr),
    .stall     (stall),
    .advance   (advance),
    .word      (word),
    .word_pc   (word_pc),
    .word_valid(word_valid)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt (fetch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Scoreboard: addresses buffered and not yet taken, next address expected
  // to be buffered, whether the in-flight read is to be thrown away.
  logic [31:0] q[$];
  logic [31:0] exp_next;
  bit          drop_pend;
  int unsigned pushes;
  bit          hold_prev;
  logic [31:0] hold_addr;
  bit          acc_seen;
  logic [31:0] acc_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // One clock: drive inputs, update scoreboard, take the edge, check outputs.
  task automatic tick(input bit r, input logic [31:0] ra, input bit s,
                      input bit adv, input bit a);
    bit          req_now;
    bit          ack_now;
    bit          take_now;
    logic [31:0] addr_now;
    redir      = r;
    redir_addr = ra;
    stall      = s;
    advance    = adv;
    req_now    = im_req;
    addr_now   = im_addr;
    ack_now    = a & req_now;
    im_ack     = ack_now;
    im_rdata   = mem_word(addr_now);
    take_now   = adv && !s && (q.size() > 0);
    acc_seen   = 1'b0;
    if (r) begin
      drop_pend = req_now && !ack_now;
      q.delete();
      exp_next = ra & ~32'h3;
    end else begin
      if (take_now) void'(q.pop_front());
      if (ack_now) begin
        if (drop_pend) begin
          drop_pend = 1'b0;
        end else begin
          n_cmp++;
          if (addr_now !== exp_next) begin
            n_mis++;
            $display("FAIL fetch_order: im_addr=%h required=%h", addr_now, exp_next);
          end
          q.push_back(exp_next);
          acc_addr = exp_next;
          acc_seen = 1'b1;
          exp_next = exp_next + 32'd4;
          pushes++;
        end
      end
    end
    hold_prev = req_now && !ack_now;
    hold_addr = addr_now;
    @(posedge clk);
    @(negedge clk);
    redir  = 1'b0;
    im_ack = 1'b0;
    n_cmp++;
    if (word_valid !== (q.size() > 0)) begin
      n_mis++;
      $display("FAIL word_valid: got=%b required=%b", word_valid, q.size() > 0);
    end
    if (q.size() > 0) begin
      n_cmp++;
      if (word_pc !== q[0] || word !== mem_word(q[0])) begin
        n_mis++;
        $display("FAIL head: pc=%h word=%h required pc=%h word=%h", word_pc, word, q[0], mem_word(q[0]));
      end
    end else begin
      n_cmp++;
      if (word !== NOP || word_pc !== exp_next) begin
        n_mis++;
        $display("FAIL empty_head: pc=%h word=%h required pc=%h word=%h", word_pc, word, exp_next, NOP);
      end
    end
    if (hold_prev) begin
      n_cmp++;
      if (im_req !== 1'b1 || im_addr !== hold_addr) begin
        n_mis++;
        $display("FAIL req_hold: req=%b addr=%h required req=1 addr=%h", im_req, im_addr, hold_addr);
      end
    end
    if (im_req === 1'b1) begin
      n_cmp++;
      if (q.size() >= DEPTH) begin
        n_mis++;
        $display("FAIL credit: request while %0d buffered, required below %0d", q.size(), DEPTH);
      end
    end
`ifdef FETCH_PERF_EN
    n_cmp++;
    if (fetch_cnt !== pushes) begin
      n_mis++;
      $display("FAIL fetch_cnt: got=%0d required=%0d", fetch_cnt, pushes);
    end
`endif
  endtask

  // One reset edge (optionally with an ack arriving in it), then reset values.
  task automatic do_reset(input bit ack_in);
    rst        = 1'b0;
    redir      = 1'b0;
    redir_addr = '0;
    stall      = 1'b0;
    advance    = 1'b0;
    im_ack     = ack_in & (im_req === 1'b1);
    im_rdata   = mem_word(im_addr);
    @(posedge clk);
    @(negedge clk);
    im_ack    = 1'b0;
    rst       = 1'b1;
    q.delete();
    exp_next  = RESET_PC;
    drop_pend = 1'b0;
    pushes    = 0;
    hold_prev = 1'b0;
    n_cmp++;
    if (im_req !== 1'b0 || im_addr !== RESET_PC) begin
      n_mis++;
      $display("FAIL reset_req: req=%b addr=%h required req=0 addr=%h", im_req, im_addr, RESET_PC);
    end
    n_cmp++;
    if (word_valid !== 1'b0 || word !== NOP || word_pc !== RESET_PC) begin
      n_mis++;
      $display("FAIL reset_head: valid=%b word=%h pc=%h required 0/%h/%h", word_valid, word, word_pc, NOP, RESET_PC);
    end
`ifdef FETCH_PERF_EN
    n_cmp++;
    if (fetch_cnt !== 32'd0) begin
      n_mis++;
      $display("FAIL reset_cnt: got=%0d required=0", fetch_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    im_ack = 1'b0;
    do_reset(1'b0);
    tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (im_req !== 1'b1 || im_addr !== RESET_PC) begin
      n_mis++;
      $display("FAIL first_req: req=%b addr=%h required req=1 addr=%h", im_req, im_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    do_reset(1'b0);
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (word_valid !== 1'b1 || word_pc !== 32'(4 * (k - 1)) || im_addr !== 32'(4 * k)) begin
        n_mis++;
        $display("FAIL stream: k=%0d valid=%b pc=%h addr=%h required 1/%h/%h",
                 k, word_valid, word_pc, im_addr, 32'(4 * (k - 1)), 32'(4 * k));
      end
    end
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, '0, 1'b1, 1'b1, 1'b1);
      if (k >= 1) begin
        n_cmp++;
        if (word_pc !== 32'h0 || word !== mem_word(32'h0)) begin
          n_mis++;
          $display("FAIL stall_head: k=%0d pc=%h word=%h required pc=0", k, word_pc, word);
        end
      end
    end
    n_cmp++;
    if (pushes !== 4 || im_req !== 1'b0) begin
      n_mis++;
      $display("FAIL stall_fill: fetched=%0d req=%b required 4/0", pushes, im_req);
    end
    for (int j = 0; j < 8; j++) begin
      tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (word_valid !== 1'b1 || word_pc !== 32'(4 * (j + 1))) begin
        n_mis++;
        $display("FAIL stall_release: j=%0d valid=%b pc=%h required 1/%h", j, word_valid, word_pc, 32'(4 * (j + 1)));
      end
    end
  endtask

  task automatic test_ack_delay();
    do_reset(1'b0);
    tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (im_req !== 1'b1 || im_addr !== RESET_PC || word_valid !== 1'b0 || word !== NOP) begin
        n_mis++;
        $display("FAIL ack_wait: k=%0d req=%b addr=%h valid=%b word=%h", k, im_req, im_addr, word_valid, word);
      end
    end
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (word_valid !== 1'b1 || word_pc !== RESET_PC || word !== mem_word(RESET_PC)) begin
      n_mis++;
      $display("FAIL ack_first: valid=%b pc=%h word=%h required 1/%h/%h", word_valid, word_pc, word, RESET_PC, mem_word(RESET_PC));
    end
  endtask

  task automatic test_redir_drop();
    bit found;
    found = 1'b0;
    do_reset(1'b0);
    for (int k = 0; k < 10 && !found; k++) begin
      if (im_req === 1'b1 && im_addr === 32'h8) found = 1'b1;
      else tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    end
    n_cmp++;
    if (!found) begin
      n_mis++;
      $display("FAIL redir_setup: request for 00000008 not seen, addr=%h", im_addr);
    end
    tick(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (word_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h8) begin
      n_mis++;
      $display("FAIL redir_drop: valid=%b req=%b addr=%h required 0/1/00000008", word_valid, im_req, im_addr);
    end
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (word_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h100) begin
      n_mis++;
      $display("FAIL redir_next: valid=%b req=%b addr=%h required 0/1/00000100", word_valid, im_req, im_addr);
    end
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (word_valid !== 1'b1 || word_pc !== 32'h100) begin
      n_mis++;
      $display("FAIL redir_first: valid=%b pc=%h required 1/00000100", word_valid, word_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want [4];
    int          got;
    want[0] = 32'hFFFF_FFF8;
    want[1] = 32'hFFFF_FFFC;
    want[2] = 32'h0000_0000;
    want[3] = 32'h0000_0004;
    got = 0;
    tick(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 16 && got < 4; k++) begin
      tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
      if (acc_seen) begin
        n_cmp++;
        if (acc_addr !== want[got]) begin
          n_mis++;
          $display("FAIL wrap_seq: #%0d addr=%h required=%h", got, acc_addr, want[got]);
        end
        got++;
      end
    end
    n_cmp++;
    if (got != 4) begin
      n_mis++;
      $display("FAIL wrap_count: fetched=%0d required=4", got);
    end
    // Same-cycle redirect, take and ack.
    for (int k = 0; k < 6 && im_req !== 1'b1; k++) tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (im_req !== 1'b1 || word_valid !== 1'b1) begin
      n_mis++;
      $display("FAIL collide_setup: req=%b valid=%b required 1/1", im_req, word_valid);
    end
    tick(1'b1, 32'h200, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (word_valid !== 1'b0 || word !== NOP || word_pc !== 32'h200) begin
      n_mis++;
      $display("FAIL collide: valid=%b word=%h pc=%h required 0/%h/00000200", word_valid, word, word_pc, NOP);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      tick($urandom_range(0, 31) == 0, $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8 && im_req !== 1'b1; k++) tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (im_req !== 1'b1) begin
      n_mis++;
      $display("FAIL rstmid_setup: req=%b required 1", im_req);
    end
    do_reset(1'b1);
    tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (im_req !== 1'b1 || im_addr !== RESET_PC) begin
      n_mis++;
      $display("FAIL rstmid_req: req=%b addr=%h required 1/%h", im_req, im_addr, RESET_PC);
    end
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (word_valid !== 1'b1 || word_pc !== RESET_PC) begin
      n_mis++;
      $display("FAIL rstmid_word: valid=%b pc=%h required 1/%h", word_valid, word_pc, RESET_PC);
    end
  endtask

  initial begin
    rst        = 1'b0;
    im_ack     = 1'b0;
    im_rdata   = '0;
    redir      = 1'b0;
    redir_addr = '0;
    stall      = 1'b0;
    advance    = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_ack_delay();
    test_redir_drop();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
